alu_nserial: RTL and testbench

Parametrised, nibble-serial successor to the CPU core's 8-bit ALU. Width is any multiple of 4, one nibble is processed per cycle (LSB first), and decimal adjust is full per-digit rather than carry-only. Operands enter and results leave through valid/ready handshakes, and the core's RDY stall is kept. Targets wider-accumulator CPU variants and a BCD coprocessor path.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_nibble.sv | 29 ++
 rtl/alu_nserial.sv | 174 +++++++++++++++++
 tb/tb_alu_nserial.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU: operation encodings and FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0111;
    localparam logic [3:0] ALU_DBL  = 4'b1011;
    localparam logic [3:0] ALU_OR   = 4'b1100;
    localparam logic [3:0] ALU_AND  = 4'b1101;
    localparam logic [3:0] ALU_XOR  = 4'b1110;
    localparam logic [3:0] ALU_PASS = 4'b1111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

endpackage

// File: rtl/alu_nibble.sv
// One-digit adder slice with optional decimal adjust for addition and
// (when the top enables it) subtraction.
module alu_nibble (
    input  logic [3:0] lhs,
    input  logic [3:0] bi_eff,
    input  logic       cin,
    input  logic       bcd,
    input  logic       sub,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw;

    always_comb begin
        raw  = {1'b0, lhs} + {1'b0, bi_eff} + {4'b0000, cin};
        sum  = raw[3:0];
        cout = raw[4];
        // Subtraction runs as A + ~B + c, so a missing carry means a borrow.
        if (bcd && !sub && (raw > 5'd9)) begin
            sum  = raw[3:0] + 4'd6;
            cout = 1'b1;
        end else if (bcd && sub && !raw[4]) begin
            sum  = raw[3:0] - 4'd6;
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/alu_nserial.sv
// Nibble-serial ALU, W bits processed LSB-first one digit per cycle.
// Define ALU_BCD_SUB_EN to add decimal adjust to subtraction.
module alu_nserial
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         rdy,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [3:0]   op,
    input  logic         right,
    input  logic [W-1:0] ai,
    input  logic [W-1:0] bi,
    input  logic         ci,
    input  logic         bcd,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         busy,
    output logic [W-1:0] out,
    output logic         co,
    output logic         v,
    output logic         z,
    output logic         n,
    output logic         hc
);

    localparam int DIGITS = W / 4;
    localparam int DW = $clog2(DIGITS + 1);
    localparam logic [DW-1:0] LAST = DW'(DIGITS - 1);

    if (((W % 4) != 0) || (W < 4)) begin : g_bad_width
        $error("alu_nserial: W must be a multiple of 4 and at least 4");
    end

    state_t state, next_state;

    logic [W-1:0]  a_sh, b_sh, acc, acc_next;
    logic [3:0]    op_r, a_n, b_n, lhs, beff, sum;
    logic          right_r, bcd_r, c, a_msb, beff_msb, rot_co, hc_run;
    logic          cout, nib_bcd, nib_sub, beff_msb_in, co_next, n_next, z_next;
    logic [DW-1:0] d;
    logic          accept;

    assign accept = (state == IDLE) && rdy && start_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (rdy) begin
            case (state)
                IDLE:    if (start_valid) next_state = RUN;
                RUN:     if (d == LAST)   next_state = DONE;
                DONE:    if (res_ready)   next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        start_ready = (state == IDLE) && rdy;
        busy        = (state != IDLE);
        res_valid   = (state == DONE);
    end

    // Operands shift right each cycle, so the active digit is always bits [3:0].
    always_comb begin
        a_n  = a_sh[3:0];
        b_n  = b_sh[3:0];
        lhs  = a_n;
        beff = 4'h0;
        if (!right_r) begin
            case (op_r)
                ALU_ADD: beff = b_n;
                ALU_SUB: beff = ~b_n;
                ALU_DBL: beff = a_n;
                ALU_OR:  lhs  = a_n | b_n;
                ALU_AND: lhs  = a_n & b_n;
                ALU_XOR: lhs  = a_n ^ b_n;
                default: lhs  = a_n;
            endcase
        end
        nib_sub = (op_r == ALU_SUB);
`ifdef ALU_BCD_SUB_EN
        nib_bcd = bcd_r && !right_r && ((op_r == ALU_ADD) || (op_r == ALU_SUB));
`else
        nib_bcd = bcd_r && !right_r && (op_r == ALU_ADD);
`endif
    end

    alu_nibble u_nibble (
        .lhs    (lhs),
        .bi_eff (beff),
        .cin    (c),
        .bcd    (nib_bcd),
        .sub    (nib_sub),
        .sum    (sum),
        .cout   (cout)
    );

    always_comb begin
        acc_next = (acc >> 4) | (W'(sum) << (W - 4));
        co_next  = right_r ? rot_co : cout;
        n_next   = acc_next[W-1];
        z_next   = (acc_next == '0);
        case (op)
            ALU_ADD: beff_msb_in = bi[W-1];
            ALU_SUB: beff_msb_in = ~bi[W-1];
            ALU_DBL: beff_msb_in = ai[W-1];
            default: beff_msb_in = 1'b0;
        endcase
        if (right) beff_msb_in = 1'b0;
    end

    // A rotate is pre-applied at accept and then streamed out like a pass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            op_r     <= 4'h0;
            right_r  <= 1'b0;
            bcd_r    <= 1'b0;
            c        <= 1'b0;
            a_msb    <= 1'b0;
            beff_msb <= 1'b0;
            rot_co   <= 1'b0;
            hc_run   <= 1'b0;
            d        <= '0;
            out      <= '0;
            co       <= 1'b0;
            v        <= 1'b0;
            z        <= 1'b0;
            n        <= 1'b0;
            hc       <= 1'b0;
        end else if (rdy) begin
            if (accept) begin
                a_sh     <= right ? {ci, ai[W-1:1]} : ai;
                b_sh     <= bi;
                acc      <= '0;
                op_r     <= op;
                right_r  <= right;
                bcd_r    <= bcd;
                c        <= (!right && ((op == ALU_ADD) || (op == ALU_SUB))) ? ci : 1'b0;
                a_msb    <= ai[W-1];
                beff_msb <= beff_msb_in;
                rot_co   <= ai[0];
                d        <= '0;
            end else if (state == RUN) begin
                a_sh <= a_sh >> 4;
                b_sh <= b_sh >> 4;
                acc  <= acc_next;
                c    <= cout;
                d    <= d + 1'b1;
                if (d == '0) hc_run <= cout;
                if (d == LAST) begin
                    out <= acc_next;
                    co  <= co_next;
                    n   <= n_next;
                    z   <= z_next;
                    v   <= a_msb ^ beff_msb ^ co_next ^ n_next;
                    hc  <= (d == '0) ? cout : hc_run;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_nserial.sv
// Directed self-checking bench for alu_nserial at W=8 and W=16.
// Expected BCD subtraction result follows ALU_BCD_SUB_EN.
module tb_alu_nserial;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset_n, rdy, right, ci, bcd, res_ready;
    logic [3:0] op;
    logic sv8, sr8, rv8, busy8, co8, v8, z8, n8, hc8;
    logic [7:0] ai8, bi8, out8;
    logic sv16, sr16, rv16, busy16, co16, v16, z16, n16, hc16;
    logic [15:0] ai16, bi16, out16;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_nserial #(.W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .rdy(rdy), .start_valid(sv8), .start_ready(sr8),
        .op(op), .right(right), .ai(ai8), .bi(bi8), .ci(ci), .bcd(bcd),
        .res_valid(rv8), .res_ready(res_ready), .busy(busy8), .out(out8),
        .co(co8), .v(v8), .z(z8), .n(n8), .hc(hc8)
    );

    alu_nserial #(.W(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .rdy(rdy), .start_valid(sv16), .start_ready(sr16),
        .op(op), .right(right), .ai(ai16), .bi(bi16), .ci(ci), .bcd(bcd),
        .res_valid(rv16), .res_ready(res_ready), .busy(busy16), .out(out16),
        .co(co16), .v(v16), .z(z16), .n(n16), .hc(hc16)
    );

    task automatic start8(input logic [3:0] o, input logic r, input logic [7:0] a,
                          input logic [7:0] b, input logic c, input logic dec);
        op = o; right = r; ai8 = a; bi8 = b; ci = c; bcd = dec; sv8 = 1'b1;
        @(posedge clk); #1;
        sv8 = 1'b0;
    endtask

    task automatic wait8(output int cyc);
        cyc = 0;
        while (!rv8 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic ack8;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        sv8 = 0; sv16 = 0; op = 4'h0; right = 0; ci = 0; bcd = 0; res_ready = 0;
        ai8 = 0; bi8 = 0; ai16 = 0; bi16 = 0; rdy = 1'b1; reset_n = 1'b0;
        #12;
        n_checks++;
        if (out8 !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h want 00", out8); end
        n_checks++;
        if ({co8, v8, n8, z8, hc8} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 00000", {co8, v8, n8, z8, hc8});
        end
        n_checks++;
        if ({rv8, busy8, sr8} !== 3'b001) begin
            n_fail++; $display("FAIL reset_hs: got %b want 001", {rv8, busy8, sr8});
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_overflow;
        int cyc;
        start8(ALU_ADD, 0, 8'h7F, 8'h01, 0, 0);
        wait8(cyc);
        n_checks++;
        if (cyc !== 2) begin n_fail++; $display("FAIL add_latency: got %0d want 2", cyc); end
        n_checks++;
        if (out8 !== 8'h80) begin n_fail++; $display("FAIL add_out: got %h want 80", out8); end
        n_checks++;
        if ({co8, v8, n8, z8, hc8} !== 5'b01101) begin
            n_fail++; $display("FAIL add_flags: got %b want 01101", {co8, v8, n8, z8, hc8});
        end
        ack8();
        n_checks++;
        if ({rv8, sr8} !== 2'b01) begin n_fail++; $display("FAIL add_release: got %b want 01", {rv8, sr8}); end
    endtask

    task automatic test_bcd_add;
        int cyc;
        start8(ALU_ADD, 0, 8'h58, 8'h46, 1, 1);
        wait8(cyc);
        n_checks++;
        if (out8 !== 8'h05) begin n_fail++; $display("FAIL bcd_add_out: got %h want 05", out8); end
        n_checks++;
        if ({co8, hc8} !== 2'b11) begin n_fail++; $display("FAIL bcd_add_co_hc: got %b want 11", {co8, hc8}); end
        ack8();
    endtask

    task automatic test_bcd_sub;
        int cyc;
        logic [7:0] exp_out;
`ifdef ALU_BCD_SUB_EN
        exp_out = 8'h29;
`else
        exp_out = 8'h2F;
`endif
        start8(ALU_SUB, 0, 8'h42, 8'h13, 1, 1);
        wait8(cyc);
        n_checks++;
        if (out8 !== exp_out) begin n_fail++; $display("FAIL bcd_sub_out: got %h want %h", out8, exp_out); end
        n_checks++;
        if (co8 !== 1'b1) begin n_fail++; $display("FAIL bcd_sub_co: got %b want 1", co8); end
        ack8();
    endtask

    task automatic test_wide_sub;
        int cyc;
        op = ALU_SUB; right = 0; ai16 = 16'h0000; bi16 = 16'h0001; ci = 1; bcd = 0; sv16 = 1'b1;
        @(posedge clk); #1;
        sv16 = 1'b0;
        cyc = 0;
        while (!rv16 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (cyc !== 4) begin n_fail++; $display("FAIL wide_latency: got %0d want 4", cyc); end
        n_checks++;
        if (out16 !== 16'hFFFF) begin n_fail++; $display("FAIL wide_out: got %h want FFFF", out16); end
        n_checks++;
        if ({co16, n16, z16} !== 3'b010) begin
            n_fail++; $display("FAIL wide_flags: got %b want 010", {co16, n16, z16});
        end
        ack8();
    endtask

    task automatic test_rotate;
        int cyc;
        start8(ALU_ADD, 1, 8'h81, 8'h55, 1, 0);
        wait8(cyc);
        n_checks++;
        if (out8 !== 8'hC0) begin n_fail++; $display("FAIL rot_out: got %h want C0", out8); end
        n_checks++;
        if (co8 !== 1'b1) begin n_fail++; $display("FAIL rot_co: got %b want 1", co8); end
        ack8();
    endtask

    task automatic test_back_to_back;
        int cyc;
        start8(ALU_XOR, 0, 8'h5A, 8'hFF, 1, 0);
        wait8(cyc);
        n_checks++;
        if ({out8, co8, n8, z8} !== {8'hA5, 3'b010}) begin
            n_fail++; $display("FAIL xor: got %h/%b want a5/010", out8, {co8, n8, z8});
        end
        ack8();
        start8(ALU_AND, 0, 8'hF0, 8'h0F, 0, 0);
        wait8(cyc);
        n_checks++;
        if ({out8, co8, n8, z8} !== {8'h00, 3'b001}) begin
            n_fail++; $display("FAIL and: got %h/%b want 00/001", out8, {co8, n8, z8});
        end
        ack8();
        start8(ALU_OR, 0, 8'h50, 8'h0A, 0, 0);
        wait8(cyc);
        n_checks++;
        if (out8 !== 8'h5A) begin n_fail++; $display("FAIL or: got %h want 5a", out8); end
        ack8();
        start8(ALU_DBL, 0, 8'h80, 8'h00, 1, 0);
        wait8(cyc);
        n_checks++;
        if ({out8, co8, v8, z8} !== {8'h00, 3'b111}) begin
            n_fail++; $display("FAIL dbl: got %h/%b want 00/111", out8, {co8, v8, z8});
        end
        ack8();
        start8(ALU_PASS, 0, 8'h3C, 8'hFF, 1, 0);
        wait8(cyc);
        n_checks++;
        if ({out8, co8} !== {8'h3C, 1'b0}) begin
            n_fail++; $display("FAIL pass: got %h/%b want 3c/0", out8, co8);
        end
        ack8();
        start8(ALU_SUB, 0, 8'h42, 8'h13, 1, 0);
        wait8(cyc);
        n_checks++;
        if ({out8, co8} !== {8'h2F, 1'b1}) begin
            n_fail++; $display("FAIL bin_sub: got %h/%b want 2f/1", out8, co8);
        end
        ack8();
    endtask

    task automatic test_stall_and_backpressure;
        int cyc;
        start8(ALU_ADD, 0, 8'h12, 8'h34, 0, 0);
        cyc = 0;
        @(posedge clk); #1;
        cyc++;
        rdy = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (rv8 !== 1'b0) begin n_fail++; $display("FAIL stall_frozen: got rv=%b want 0", rv8); end
        rdy = 1'b1;
        while (!rv8 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (cyc !== 5) begin n_fail++; $display("FAIL stall_latency: got %0d want 5", cyc); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({out8, rv8, sr8} !== {8'h46, 2'b10}) begin
                n_fail++; $display("FAIL backpressure[%0d]: got %h/%b want 46/10", i, out8, {rv8, sr8});
            end
            @(posedge clk); #1;
        end
        ack8();
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        start8(ALU_ADD, 0, 8'h01, 8'h01, 0, 0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({out8, co8, v8, n8, z8, hc8, rv8, busy8} !== 15'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h/%b want 00/0000000", out8, {co8, v8, n8, z8, hc8, rv8, busy8});
        end
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        start8(ALU_ADD, 0, 8'h11, 8'h22, 0, 0);
        wait8(cyc);
        n_checks++;
        if ({cyc[3:0], out8} !== {4'd2, 8'h33}) begin
            n_fail++; $display("FAIL after_reset: got %0d/%h want 2/33", cyc, out8);
        end
        ack8();
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_bcd_add();
        test_bcd_sub();
        test_wide_sub();
        test_rotate();
        test_back_to_back();
        test_stall_and_backpressure();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
